// File: rtl/uart_tx_core.sv
// ---------------------------------------------------------------------------
// uart_tx_core
// Purpose : Serialises one parallel word into an asynchronous UART frame:
//           start bit (0), DATA_BITS data bits LSB first, optional parity
//           bit, then STOP_BITS stop bits (1). Each bit lasts CLKS_PER_BIT
//           clk cycles. A new request arriving in the final stop cycle
//           chains straight into the next frame without an idle gap.
// Ports   :
//   clk   in   1          rising-edge clock
//   rst   in   1          asynchronous active-low reset
//   send  in   1          transmit request, honoured in IDLE or final stop cycle
//   data  in   DATA_BITS  word to transmit, captured only at the load edge
//   tx    out  1          serial line, idles at 1 (registered)
//   busy  out  1          high while a frame is in progress (registered)
//   done  out  1          high during the last clk cycle of a frame (registered)
// ---------------------------------------------------------------------------
module uart_tx_core #(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 send,
   input  logic [DATA_BITS-1:0] data,
   output logic                 tx,
   output logic                 busy,
   output logic                 done
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = $clog2(DATA_BITS + 1);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
   // The bit counter doubles as the stop-bit counter while in STOP.
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
   localparam logic              PAR_INV   = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   // Parity of the captured word; odd parity is the inverted XOR.
   function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
      return (^d) ^ PAR_INV;
   endfunction

   state_t                r_state;
   logic [BAUD_W-1:0]     r_baud;
   logic [BIT_W-1:0]      r_bit;
   logic [DATA_BITS-1:0]  r_shift;
   logic                  r_parity;
   logic                  r_tx;
   logic                  r_busy;
   logic                  r_done;

   state_t                w_state_next;
   logic [BAUD_W-1:0]     w_baud_next;
   logic [BIT_W-1:0]      w_bit_next;
   logic [DATA_BITS-1:0]  w_shift_next;
   logic                  w_parity_next;
   logic                  w_tx_next;
   logic                  w_busy_next;
   logic                  w_done_next;
   logic                  w_tick;
   logic                  w_load;

   // Next-state, counter, shift-register and output-next decoding.
   always_comb begin
      w_state_next  = r_state;
      w_baud_next   = r_baud;
      w_bit_next    = r_bit;
      w_shift_next  = r_shift;
      w_parity_next = r_parity;
      w_load        = 1'b0;
      w_tick        = (r_baud == BAUD_LAST);

      case (r_state)
         S_IDLE: begin
            if (send) begin
               w_load = 1'b1;
            end else begin
               w_load = 1'b0;
            end
         end
         S_START: begin
            if (w_tick) begin
               w_state_next = S_DATA;
               w_baud_next  = '0;
               w_bit_next   = '0;
            end else begin
               w_baud_next = r_baud + BAUD_W'(1);
            end
         end
         S_DATA: begin
            if (w_tick) begin
               w_baud_next  = '0;
               w_shift_next = {1'b0, r_shift[DATA_BITS-1:1]};
               if (r_bit == DATA_LAST) begin
                  w_bit_next   = '0;
                  w_state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
               end else begin
                  w_bit_next = r_bit + BIT_W'(1);
               end
            end else begin
               w_baud_next = r_baud + BAUD_W'(1);
            end
         end
         S_PARITY: begin
            if (w_tick) begin
               w_state_next = S_STOP;
               w_baud_next  = '0;
               w_bit_next   = '0;
            end else begin
               w_baud_next = r_baud + BAUD_W'(1);
            end
         end
         S_STOP: begin
            if (w_tick) begin
               w_baud_next = '0;
               if (r_bit == STOP_LAST) begin
                  w_bit_next = '0;
                  // A request in the final stop cycle chains the next frame.
                  if (send) begin
                     w_load = 1'b1;
                  end else begin
                     w_state_next = S_IDLE;
                  end
               end else begin
                  w_bit_next = r_bit + BIT_W'(1);
               end
            end else begin
               w_baud_next = r_baud + BAUD_W'(1);
            end
         end
         default: begin
            w_state_next  = S_IDLE;
            w_baud_next   = '0;
            w_bit_next    = '0;
            w_shift_next  = '0;
            w_parity_next = 1'b0;
         end
      endcase

      if (w_load) begin
         w_state_next  = S_START;
         w_baud_next   = '0;
         w_bit_next    = '0;
         w_shift_next  = data;
         w_parity_next = calc_parity(data);
      end else begin
         w_state_next = w_state_next;
      end

      // Outputs are derived from next-state values so the registered copies
      // line up with the state they describe.
      case (w_state_next)
         S_IDLE:   w_tx_next = 1'b1;
         S_START:  w_tx_next = 1'b0;
         S_DATA:   w_tx_next = w_shift_next[0];
         S_PARITY: w_tx_next = w_parity_next;
         S_STOP:   w_tx_next = 1'b1;
         default:  w_tx_next = 1'b1;
      endcase
      w_busy_next = (w_state_next != S_IDLE);
      w_done_next = (w_state_next == S_STOP) && (w_baud_next == BAUD_LAST) &&
                    (w_bit_next == STOP_LAST);
   end

   // State, counters, datapath and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_baud   <= '0;
         r_bit    <= '0;
         r_shift  <= '0;
         r_parity <= 1'b0;
         r_tx     <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_baud   <= w_baud_next;
         r_bit    <= w_bit_next;
         r_shift  <= w_shift_next;
         r_parity <= w_parity_next;
         r_tx     <= w_tx_next;
         r_busy   <= w_busy_next;
         r_done   <= w_done_next;
      end
   end

   assign tx   = r_tx;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_uart_tx_core.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_core
// Purpose : Scoreboard bench for uart_tx_core over five configurations.
//           Stimulus pushes the hand-computed frame (bit i = i-th bit on the
//           line) into a queue; one monitor per instance captures tx while
//           busy and, on done, pops and checks frame length and bit levels.
//   inst 0 : 8 data, 4 clk/bit, no parity, 1 stop
//   inst 1 : 8 data, 4 clk/bit, even parity, 1 stop
//   inst 2 : 8 data, 4 clk/bit, odd parity, 1 stop
//   inst 3 : 8 data, 4 clk/bit, no parity, 2 stop
//   inst 4 : 5 data, 2 clk/bit, no parity, 2 stop
// ---------------------------------------------------------------------------
module tb_uart_tx_core;

   typedef struct {
      int          id;
      logic [15:0] bits;
      int          nbits;
      int          cpb;
   } exp_t;

   logic       clk;
   logic       rst;
   logic [4:0] send_v;
   logic [4:0] tx_v;
   logic [4:0] busy_v;
   logic [4:0] done_v;
   logic [8:0] data_a [5];

   exp_t sb_q[$];
   int   n_chk = 0;
   int   n_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   uart_tx_core #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
      .clk(clk), .rst(rst), .send(send_v[0]), .data(data_a[0][7:0]),
      .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
   uart_tx_core #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
      .clk(clk), .rst(rst), .send(send_v[1]), .data(data_a[1][7:0]),
      .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
   uart_tx_core #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
      .clk(clk), .rst(rst), .send(send_v[2]), .data(data_a[2][7:0]),
      .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));
   uart_tx_core #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
      .clk(clk), .rst(rst), .send(send_v[3]), .data(data_a[3][7:0]),
      .tx(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]));
   uart_tx_core #(.DATA_BITS(5), .CLKS_PER_BIT(2), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u4 (
      .clk(clk), .rst(rst), .send(send_v[4]), .data(data_a[4][4:0]),
      .tx(tx_v[4]), .busy(busy_v[4]), .done(done_v[4]));

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
      n_chk++;
      if (got !== req) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", nm, got, req);
      end
   endtask

   task automatic push_exp(input int id, input logic [15:0] bits, input int nbits, input int cpb);
      exp_t e;
      e.id = id; e.bits = bits; e.nbits = nbits; e.cpb = cpb;
      sb_q.push_back(e);
   endtask

   // Compare one captured frame against the oldest expectation.
   task automatic check_frame(input int id, input int n, input logic [63:0] s);
      exp_t        e;
      logic        ok;
      logic [15:0] gv;
      if (sb_q.size() == 0) begin
         n_chk++;
         n_err++;
         $display("FAIL unexpected_frame: inst %0d got a %0d-cycle frame, required none", id, n);
      end else begin
         e = sb_q.pop_front();
         chk($sformatf("frame_inst(%0d)", id), id, e.id);
         chk($sformatf("frame_len(%0d)", id), n, e.nbits * e.cpb);
         ok = 1'b1;
         gv = '0;
         for (int i = 0; i < e.nbits; i++) begin
            gv[i] = s[i * e.cpb + e.cpb / 2];
            for (int j = 0; j < e.cpb; j++) begin
               if (s[i * e.cpb + j] !== e.bits[i]) ok = 1'b0;
            end
         end
         n_chk++;
         if (!ok) begin
            n_err++;
            $display("FAIL frame_bits(%0d): got %0h required %0h", id, gv, e.bits);
         end
      end
   endtask

   for (genvar g = 0; g < 5; g++) begin : g_mon
      initial begin : mon
         int          cnt;
         logic [63:0] samp;
         cnt  = 0;
         samp = '0;
         forever begin
            @(negedge clk);
            if (!rst) begin
               cnt  = 0;
               samp = '0;
            end else begin
               if (busy_v[g] && cnt < 64) begin
                  samp[cnt] = tx_v[g];
                  cnt++;
               end
               if (done_v[g]) begin
                  check_frame(g, cnt, samp);
                  cnt  = 0;
                  samp = '0;
               end
            end
         end
      end
   end

   // Single-cycle request; checks registered start-of-frame latency.
   task automatic pulse(input int id, input logic [8:0] d);
      @(negedge clk);
      chk("pre_load_busy", busy_v[id], 32'd0);
      data_a[id] = d;
      send_v[id] = 1'b1;
      @(posedge clk);
      #1;
      send_v[id] = 1'b0;
      chk("load_busy", busy_v[id], 32'd1);
      chk("load_tx", tx_v[id], 32'd0);
   endtask

   initial begin : stim
      logic busy_ok;
      rst    = 1'b0;
      send_v = '0;
      for (int i = 0; i < 5; i++) data_a[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_tx", tx_v, 32'h1F);
      chk("reset_busy", busy_v, 32'h0);
      chk("reset_done", done_v, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);

      // Basic frame 0xA5: 0,1,0,1,0,0,1,0,1,1 -> 10'h34A, 40 cycles.
      push_exp(0, 16'h034A, 10, 4);
      pulse(0, 9'h0A5);
      repeat (45) @(posedge clk);

      // Even parity 0xA5: parity 0 -> 11'h54A, 44 cycles.
      push_exp(1, 16'h054A, 11, 4);
      pulse(1, 9'h0A5);
      repeat (48) @(posedge clk);

      // Odd parity 0x01: XOR 1 inverted -> parity 0 -> 11'h402.
      push_exp(2, 16'h0402, 11, 4);
      pulse(2, 9'h001);
      repeat (48) @(posedge clk);

      // Back-to-back with two stop bits: 0x3C -> 11'h678, 0xC3 -> 11'h786.
      push_exp(3, 16'h0678, 11, 4);
      push_exp(3, 16'h0786, 11, 4);
      @(negedge clk);
      data_a[3] = 9'h03C;
      send_v[3] = 1'b1;
      @(posedge clk);
      #1;
      chk("b2b_load_busy", busy_v[3], 32'd1);
      data_a[3] = 9'h0C3;
      busy_ok = 1'b1;
      for (int i = 1; i < 44; i++) begin
         @(posedge clk);
         #1;
         if (busy_v[3] !== 1'b1) busy_ok = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("b2b_no_gap_tx", tx_v[3], 32'd0);
      chk("b2b_no_gap_busy", busy_v[3], 32'd1);
      send_v[3] = 1'b0;
      for (int i = 45; i < 88; i++) begin
         @(posedge clk);
         #1;
         if (busy_v[3] !== 1'b1) busy_ok = 1'b0;
      end
      chk("b2b_busy_held", busy_ok, 32'd1);
      repeat (6) @(posedge clk);
      #1;
      chk("b2b_idle_after", busy_v[3], 32'd0);

      // Ignored send plus data change mid-frame: 0x96 -> 10'h32C, no second frame.
      push_exp(0, 16'h032C, 10, 4);
      pulse(0, 9'h096);
      repeat (10) @(posedge clk);
      @(negedge clk);
      data_a[0] = 9'h0FF;
      send_v[0] = 1'b1;
      @(negedge clk);
      send_v[0] = 1'b0;
      data_a[0] = 9'h000;
      repeat (75) @(posedge clk);
      #1;
      chk("ignored_send_idle", busy_v[0], 32'd0);

      // Reset during the third data bit: frame aborted, no done, no restart.
      pulse(0, 9'h0A5);
      repeat (13) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_async_tx", tx_v[0], 32'd1);
      chk("rst_async_busy", busy_v[0], 32'd0);
      chk("rst_async_done", done_v[0], 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (50) @(posedge clk);
      #1;
      chk("rst_no_restart", busy_v[0], 32'd0);

      // Narrow config 5'h1F: 0,1,1,1,1,1,1,1 -> 8'hFE, 16 cycles.
      push_exp(4, 16'h00FE, 8, 2);
      pulse(4, 9'h01F);
      repeat (20) @(posedge clk);

      chk("scoreboard_drained", sb_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
